aes_axil_regs: RTL
==================

// Module: aes_axil_regs
// PURPOSE
// AXI4-Lite slave register file between the PicoRV32 AXI4-Lite master and the AES accelerator top. Holds key, plaintext and ciphertext operands, issues single-cycle start pulses, captures results and exposes status for polling by the CPU.
// PARAMETERS
// ADDR_W     8   byte-address width of s_awaddr/s_araddr; addr[1:0] ignored
// SLVERR_EN  1   1: unmapped or read-only access returns SLVERR (2'b10); 0: always OKAY
// PORTS
// clk                  in   1    single clock, all state on rising edge
// resetn               in   1    asynchronous, active-low reset
// s_awvalid/s_awready  in/out 1  AW handshake
// s_awaddr             in   ADDR_W write address
// s_wvalid/s_wready    in/out 1  W handshake
// s_wdata              in   32   write data
// s_wstrb              in   4    byte strobes
// s_bvalid/s_bready    out/in 1  B handshake
// s_bresp              out  2    write response
// s_arvalid/s_arready  in/out 1  AR handshake
// s_araddr             in   ADDR_W read address
// s_rvalid/s_rready    out/in 1  R handshake
// s_rdata              out  32   read data
// s_rresp              out  2    read response
// pt_valid             out  1    encrypt start pulse
// pt_encr              out  128  plaintext to encrypt
// pt_in_en             in   1    encrypt engine idle
// ct_rdy               in   1    encrypt result valid pulse
// ct_encr              in   128  encrypt result
// ct_valid             out  1    decrypt start pulse
// ct_decr              out  128  ciphertext to decrypt
// ct_in_en             in   1    decrypt engine idle
// pt_rdy               in   1    decrypt result valid pulse
// pt_decr              in   128  decrypt result
// key_len              out  2    key length code, 0 = none (a 0->nonzero edge starts key expansion)
// short_key            out  256  key, [255:128] = first subkey
// key_mem_status/key_inp_ready/error  in 1 each  accelerator status
// BEHAVIOUR
// Map (word, MSW first): 0x00-0x1C KEY0-7 -> short_key[255:224]..[31:0]; 0x20-0x2C PT0-3 -> pt_encr; 0x30-0x3C CT0-3 -> ct_decr; 0x40 CTRL (RW); 0x44 STATUS (RO); 0x50-0x5C ENC_RES0-3 (RO); 0x60-0x6C DEC_RES0-3 (RO).
// CTRL: [1:0] key_len (held; reads back), [2] START_ENC, [3] START_DEC (write-1 pulse, read 0). CTRL acts only if wstrb[0]=1; KEY/PT/CT honour wstrb per byte.
// STATUS = {25'b0, drop, error, key_inp_ready, key_mem_status, ct_in_en, dec_done, enc_done} (bit6..0).
// Reset: all registers, key_len, pt_valid, ct_valid, s_bvalid, s_rvalid 0; s_awready, s_wready, s_arready 1; resp 0.
// Write: AW and W each accepted independently into a holding slot (ready drops once that slot is full). The register update happens in the cycle after both slots are full; s_bvalid is raised in the same cycle. s_bvalid holds until s_bready; both slots are freed on the B handshake. At most one write is outstanding.
// Read: accept when !s_rvalid. s_rvalid with data the next cycle; s_rdata/s_rresp held stable until s_rready. Unmapped -> data 0, SLVERR if SLVERR_EN.
// Writes to RO/unmapped addresses: no state change; SLVERR if SLVERR_EN.
// START_ENC: pt_valid=1 for exactly one cycle, in the cycle after the write commits, only if pt_in_en=1. START_DEC is identical, using ct_valid and ct_in_en. A start with engine busy is dropped and sets sticky drop.
// Accepted START_ENC clears enc_done. ct_rdy latches ct_encr into ENC_RES and sets enc_done. The DEC path is symmetric (pt_rdy latches pt_decr into DEC_RES and sets dec_done).
// If a result pulse coincides with an accepted start of the same path, set wins. drop clears on a CTRL write with wdata[31]=1.
// PT/CT writes while the matching engine is busy are applied; the AES core has already sampled its operand.
// resetn asserted mid-transaction: everything returns to reset values immediately, and in-flight B/R responses are discarded.
// TESTING
// Reset: resetn low mid-write -> bvalid=0, awready=wready=arready=1, key_len=0, all RES regs read 0.
// W before AW (W at t, AW at t+3), bready held low 4 cycles -> single commit, bvalid stable, OKAY, register updated.
// Write KEY0-3=0x00010203..0x0C0D0E0F, CTRL=0x1 (128b) -> key_len=1. PT=FIPS-197 vector, CTRL=0x4 -> pt_valid 1 cycle; ENC_RES=0x69c4e0d8_6a7b0430_d8cdb780_70b4c55a, enc_done=1.
// CTRL=0xC while both engines are busy -> no pulses, STATUS.drop=1; CTRL=0x80000000 -> drop=0.
// Read 0x48 and write 0x50 -> rresp/bresp=2'b10, rdata=0, ENC_RES unchanged. Repeat with SLVERR_EN=0 -> OKAY.
// Write PT0 with wstrb=4'b0010, wdata=0xAABBCCDD -> only pt_encr[111:104]=0xCC changes.

Source files
------------

// File: rtl/aes_axil_regs_if.sv
// rtl/aes_axil_regs_if.sv - AXI4-Lite bus bundle between the CPU master and the AES register file
// Ports: AW (s_awvalid/s_awready/s_awaddr), W (s_wvalid/s_wready/s_wdata/s_wstrb),
//        B (s_bvalid/s_bready/s_bresp), AR (s_arvalid/s_arready/s_araddr),
//        R (s_rvalid/s_rready/s_rdata/s_rresp); master and slave modports.
interface aes_axil_regs_if #(
    parameter int ADDR_W = 8
);
    logic              s_awvalid;
    logic              s_awready;
    logic [ADDR_W-1:0] s_awaddr;
    logic              s_wvalid;
    logic              s_wready;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic              s_bvalid;
    logic              s_bready;
    logic [1:0]        s_bresp;
    logic              s_arvalid;
    logic              s_arready;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_rvalid;
    logic              s_rready;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;

    modport master (
        output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_rready,
        input  s_awready, s_wready, s_bvalid, s_bresp, s_arready,
               s_rvalid, s_rdata, s_rresp
    );

    modport slave (
        input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_rready,
        output s_awready, s_wready, s_bvalid, s_bresp, s_arready,
               s_rvalid, s_rdata, s_rresp
    );
endinterface

// File: rtl/aes_axil_regs.sv
// rtl/aes_axil_regs.sv - AXI4-Lite register file holding AES key/operands/results with start pulses
// Ports: clk, resetn (async active-low); s = AXI4-Lite slave bus;
//        encrypt side pt_valid/pt_encr out, pt_in_en/ct_rdy/ct_encr in;
//        decrypt side ct_valid/ct_decr out, ct_in_en/pt_rdy/pt_decr in;
//        key_len/short_key out; key_mem_status/key_inp_ready/error status in.
module aes_axil_regs #(
    parameter int ADDR_W    = 8,
    parameter bit SLVERR_EN = 1'b1
) (
    input  logic           clk,
    input  logic           resetn,
    aes_axil_regs_if.slave s,
    output logic           pt_valid,
    output logic [127:0]   pt_encr,
    input  logic           pt_in_en,
    input  logic           ct_rdy,
    input  logic [127:0]   ct_encr,
    output logic           ct_valid,
    output logic [127:0]   ct_decr,
    input  logic           ct_in_en,
    input  logic           pt_rdy,
    input  logic [127:0]   pt_decr,
    output logic [1:0]     key_len,
    output logic [255:0]   short_key,
    input  logic           key_mem_status,
    input  logic           key_inp_ready,
    input  logic           error
);
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_ERR  = SLVERR_EN ? 2'b10 : 2'b00;

    typedef enum logic [2:0] {R_KEY, R_PT, R_CT, R_CTRL, R_STATUS, R_ENC, R_DEC, R_NONE} region_t;

    // Element 0 of each array is the most significant word of the flattened vector.
    logic [0:7][31:0] key_q;
    logic [0:3][31:0] pt_q, ct_q, enc_res_q, dec_res_q;
    logic [1:0]       key_len_q;
    logic             enc_done_q, dec_done_q, drop_q;
    logic             pt_valid_q, ct_valid_q;

    logic              aw_full_q, w_full_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic              bvalid_q, rvalid_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [31:0]       rdata_q;

    function automatic region_t region(input logic [ADDR_W-1:0] a);
        int unsigned wi;
        wi = 32'(a >> 2);
        if (wi < 8)                  return R_KEY;
        else if (wi < 12)            return R_PT;
        else if (wi < 16)            return R_CT;
        else if (wi == 16)           return R_CTRL;
        else if (wi == 17)           return R_STATUS;
        else if (wi >= 20 && wi < 24) return R_ENC;
        else if (wi >= 24 && wi < 28) return R_DEC;
        else                         return R_NONE;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    // Read mux
    region_t     rd_reg;
    logic [31:0] rd_data;
    logic        rd_ok;

    always_comb begin
        rd_reg  = region(s.s_araddr);
        rd_data = '0;
        rd_ok   = 1'b1;
        case (rd_reg)
            R_KEY:    rd_data = key_q[s.s_araddr[4:2]];
            R_PT:     rd_data = pt_q[s.s_araddr[3:2]];
            R_CT:     rd_data = ct_q[s.s_araddr[3:2]];
            R_CTRL:   rd_data = {30'd0, key_len_q};
            R_STATUS: rd_data = {25'd0, drop_q, error, key_inp_ready, key_mem_status,
                                 ct_in_en, dec_done_q, enc_done_q};
            R_ENC:    rd_data = enc_res_q[s.s_araddr[3:2]];
            R_DEC:    rd_data = dec_res_q[s.s_araddr[3:2]];
            default:  rd_ok   = 1'b0;
        endcase
    end

    // Write commit: both slots full and no response outstanding.
    region_t wr_reg;
    logic    commit, wr_ok, ctrl_wr;
    logic    enc_go, enc_drop, dec_go, dec_drop;

    always_comb begin
        wr_reg   = region(aw_addr_q);
        commit   = aw_full_q && w_full_q && !bvalid_q;
        wr_ok    = (wr_reg == R_KEY) || (wr_reg == R_PT) || (wr_reg == R_CT) || (wr_reg == R_CTRL);
        ctrl_wr  = commit && (wr_reg == R_CTRL) && w_strb_q[0];
        enc_go   = ctrl_wr && w_data_q[2] && pt_in_en;
        enc_drop = ctrl_wr && w_data_q[2] && !pt_in_en;
        dec_go   = ctrl_wr && w_data_q[3] && ct_in_en;
        dec_drop = ctrl_wr && w_data_q[3] && !ct_in_en;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_q      <= '0;
            pt_q       <= '0;
            ct_q       <= '0;
            enc_res_q  <= '0;
            dec_res_q  <= '0;
            key_len_q  <= '0;
            enc_done_q <= 1'b0;
            dec_done_q <= 1'b0;
            drop_q     <= 1'b0;
            pt_valid_q <= 1'b0;
            ct_valid_q <= 1'b0;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            pt_valid_q <= enc_go;
            ct_valid_q <= dec_go;

            if (s.s_awvalid && !aw_full_q) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= s.s_awaddr;
            end
            if (s.s_wvalid && !w_full_q) begin
                w_full_q <= 1'b1;
                w_data_q <= s.s_wdata;
                w_strb_q <= s.s_wstrb;
            end

            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_ERR;
                case (wr_reg)
                    R_KEY: key_q[aw_addr_q[4:2]] <= merge(key_q[aw_addr_q[4:2]], w_data_q, w_strb_q);
                    R_PT:  pt_q[aw_addr_q[3:2]]  <= merge(pt_q[aw_addr_q[3:2]], w_data_q, w_strb_q);
                    R_CT:  ct_q[aw_addr_q[3:2]]  <= merge(ct_q[aw_addr_q[3:2]], w_data_q, w_strb_q);
                    R_CTRL: if (w_strb_q[0]) key_len_q <= w_data_q[1:0];
                    default: ;
                endcase
            end

            // Slots free only on the B handshake, which keeps one write outstanding.
            if (bvalid_q && s.s_bready) begin
                bvalid_q  <= 1'b0;
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
            end

            // A drop in the same write as a clear request stays set.
            if (ctrl_wr && w_data_q[31]) drop_q <= 1'b0;
            if (enc_drop || dec_drop)    drop_q <= 1'b1;

            // Result pulse wins over the clear from a coincident accepted start.
            if (enc_go) enc_done_q <= 1'b0;
            if (ct_rdy) begin
                enc_done_q <= 1'b1;
                enc_res_q  <= ct_encr;
            end
            if (dec_go) dec_done_q <= 1'b0;
            if (pt_rdy) begin
                dec_done_q <= 1'b1;
                dec_res_q  <= pt_decr;
            end

            if (rvalid_q && s.s_rready) rvalid_q <= 1'b0;
            if (s.s_arvalid && !rvalid_q) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_ok ? RESP_OKAY : RESP_ERR;
            end
        end
    end

    assign s.s_awready = !aw_full_q;
    assign s.s_wready  = !w_full_q;
    assign s.s_bvalid  = bvalid_q;
    assign s.s_bresp   = bresp_q;
    assign s.s_arready = !rvalid_q;
    assign s.s_rvalid  = rvalid_q;
    assign s.s_rdata   = rdata_q;
    assign s.s_rresp   = rresp_q;

    assign pt_valid  = pt_valid_q;
    assign ct_valid  = ct_valid_q;
    assign pt_encr   = pt_q;
    assign ct_decr   = ct_q;
    assign key_len   = key_len_q;
    assign short_key = key_q;
endmodule
